// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
// Trap sequencer between the pipeline and csr_reg. It arbitrates synchronous
// exceptions, machine interrupts and mret requests, performs the CSR reads and
// writes each one needs (mtvec, mepc, mstatus), and issues a one-cycle PC
// redirect to fetch.
//
// Ports
//   clk, reset                       clock, synchronous active-low reset
//   exc_valid/cause/pc/val           exception request from execute
//   mret_valid                       mret request from execute
//   int_ok, int_pc                   interruptible boundary, next PC
//   mstatus_mie_in, mstatus_mpie_in  status bits from csr_reg
//   mip_*_in, mie_*_in               pending / enable bits from csr_reg
//   csr_rdata                        csr_reg dout (combinational from addr)
//   csr_addr/read_en/write_en/write_type/wdata   CSR access port
//   trap_mie/mpie/int/pc_out/cause/val/wr_en     csr_reg trap-write port
//   redirect_valid, redirect_pc      one-cycle redirect to fetch
//   busy                             high outside IDLE (pipeline stalls)
module csr_trap_ctrl #(
   parameter logic [11:0] MTVEC_ADDR   = 12'h305,
   parameter logic [11:0] MEPC_ADDR    = 12'h341,
   parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_valid,
   input  logic [30:0] exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_val,
   input  logic        mret_valid,
   input  logic        int_ok,
   input  logic [31:0] int_pc,
   input  logic        mstatus_mie_in,
   input  logic        mstatus_mpie_in,
   input  logic        mip_msip_in,
   input  logic        mip_mtip_in,
   input  logic        mip_meip_in,
   input  logic        mie_msie_in,
   input  logic        mie_mtie_in,
   input  logic        mie_meie_in,
   input  logic [31:0] csr_rdata,
   output logic [11:0] csr_addr,
   output logic        csr_read_en,
   output logic        csr_write_en,
   output logic [1:0]  csr_write_type,
   output logic [31:0] csr_wdata,
   output logic        trap_mie,
   output logic        trap_mpie,
   output logic        trap_int,
   output logic [31:0] trap_pc_out,
   output logic [30:0] trap_cause,
   output logic [31:0] trap_val,
   output logic        trap_wr_en,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TRAP_WR  = 3'd1,
      MRET_RD  = 3'd2,
      MRET_WR  = 3'd3,
      REDIRECT = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic        int_reg, int_next;
   logic        mpie_reg, mpie_next;
   logic [30:0] cause_reg, cause_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] val_reg, val_next;
   logic [31:0] target_reg, target_next;

   // Index 2 = MEI, 1 = MSI, 0 = MTI
   logic [2:0] ip_vec, ie_vec, pend_vec;
   assign ip_vec = {mip_meip_in, mip_msip_in, mip_mtip_in};
   assign ie_vec = {mie_meie_in, mie_msie_in, mie_mtie_in};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pend
         assign pend_vec[gi] = ip_vec[gi] & ie_vec[gi];
      end
   endgenerate

   logic        int_take;
   logic [30:0] int_cause;
   assign int_take  = int_ok & mstatus_mie_in & (|pend_vec);
   assign int_cause = pend_vec[2] ? 31'd11 : (pend_vec[1] ? 31'd3 : 31'd7);

   // Vector computed from the mtvec value read during TRAP_WR; mode 1 vectors
   // interrupts only, every other mode/kind goes to the base.
   logic [31:0] vec_base, vec_target;
   assign vec_base   = {csr_rdata[31:2], 2'b00};
   assign vec_target = (csr_rdata[1:0] == 2'd1 && int_reg)
                       ? vec_base + {cause_reg[29:0], 2'b00}
                       : vec_base;

   // State register and latches
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         int_reg    <= 1'b0;
         mpie_reg   <= 1'b0;
         cause_reg  <= '0;
         pc_reg     <= '0;
         val_reg    <= '0;
         target_reg <= '0;
      end else begin
         state_reg  <= state_next;
         int_reg    <= int_next;
         mpie_reg   <= mpie_next;
         cause_reg  <= cause_next;
         pc_reg     <= pc_next;
         val_reg    <= val_next;
         target_reg <= target_next;
      end
   end

   // Next state and latch updates
   always_comb begin
      state_next  = state_reg;
      int_next    = int_reg;
      mpie_next   = mpie_reg;
      cause_next  = cause_reg;
      pc_next     = pc_reg;
      val_next    = val_reg;
      target_next = target_reg;
      case (state_reg)
         IDLE: begin
            if (exc_valid) begin
               state_next = TRAP_WR;
               int_next   = 1'b0;
               cause_next = exc_cause;
               pc_next    = exc_pc;
               val_next   = exc_val;
               mpie_next  = mstatus_mie_in;
            end else if (int_take) begin
               state_next = TRAP_WR;
               int_next   = 1'b1;
               cause_next = int_cause;
               pc_next    = int_pc;
               val_next   = '0;
               mpie_next  = mstatus_mie_in;
            end else if (mret_valid) begin
               state_next = MRET_RD;
            end
         end
         TRAP_WR: begin
            target_next = vec_target;
            state_next  = REDIRECT;
         end
         MRET_RD: begin
            target_next = csr_rdata & ~32'h3;
            state_next  = MRET_WR;
         end
         MRET_WR:  state_next = REDIRECT;
         REDIRECT: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Outputs, purely from state and latches (plus mpie for the mstatus write)
   always_comb begin
      csr_addr       = '0;
      csr_read_en    = 1'b0;
      csr_write_en   = 1'b0;
      csr_write_type = 2'd0;
      csr_wdata      = '0;
      trap_mie       = 1'b0;
      trap_mpie      = 1'b0;
      trap_int       = 1'b0;
      trap_pc_out    = '0;
      trap_cause     = '0;
      trap_val       = '0;
      trap_wr_en     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = (state_reg != IDLE);
      case (state_reg)
         TRAP_WR: begin
            trap_wr_en  = 1'b1;
            trap_mpie   = mpie_reg;
            trap_int    = int_reg;
            trap_pc_out = pc_reg;
            trap_cause  = cause_reg;
            trap_val    = val_reg;
            csr_addr    = MTVEC_ADDR;
            csr_read_en = 1'b1;
         end
         MRET_RD: begin
            csr_addr    = MEPC_ADDR;
            csr_read_en = 1'b1;
         end
         MRET_WR: begin
            csr_addr       = MSTATUS_ADDR;
            csr_write_en   = 1'b1;
            csr_write_type = 2'd0;
            csr_wdata      = 32'h80 | {28'd0, mstatus_mpie_in, 3'd0};
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = target_reg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: table of request vectors with expected trap,
// CSR-write and redirect results, checked through a scoreboard, plus hand
// sequences for reset behaviour.
module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_valid, mret_valid, int_ok;
   logic [30:0] exc_cause;
   logic [31:0] exc_pc, exc_val, int_pc;
   logic        mstatus_mie_in, mstatus_mpie_in;
   logic        mip_msip_in, mip_mtip_in, mip_meip_in;
   logic        mie_msie_in, mie_mtie_in, mie_meie_in;
   logic [31:0] csr_rdata;
   logic [11:0] csr_addr;
   logic        csr_read_en, csr_write_en;
   logic [1:0]  csr_write_type;
   logic [31:0] csr_wdata;
   logic        trap_mie, trap_mpie, trap_int, trap_wr_en;
   logic [31:0] trap_pc_out, trap_val;
   logic [30:0] trap_cause;
   logic        redirect_valid, busy;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   csr_trap_ctrl dut (
      .clk(clk), .reset(reset),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_val(exc_val),
      .mret_valid(mret_valid), .int_ok(int_ok), .int_pc(int_pc),
      .mstatus_mie_in(mstatus_mie_in), .mstatus_mpie_in(mstatus_mpie_in),
      .mip_msip_in(mip_msip_in), .mip_mtip_in(mip_mtip_in), .mip_meip_in(mip_meip_in),
      .mie_msie_in(mie_msie_in), .mie_mtie_in(mie_mtie_in), .mie_meie_in(mie_meie_in),
      .csr_rdata(csr_rdata), .csr_addr(csr_addr), .csr_read_en(csr_read_en),
      .csr_write_en(csr_write_en), .csr_write_type(csr_write_type), .csr_wdata(csr_wdata),
      .trap_mie(trap_mie), .trap_mpie(trap_mpie), .trap_int(trap_int),
      .trap_pc_out(trap_pc_out), .trap_cause(trap_cause), .trap_val(trap_val),
      .trap_wr_en(trap_wr_en), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   // Minimal csr_reg read model: combinational dout from addr/read_en
   logic [31:0] mtvec_m, mepc_m;
   always_comb begin
      csr_rdata = 32'd0;
      if (csr_read_en) begin
         if (csr_addr == 12'h305)      csr_rdata = mtvec_m;
         else if (csr_addr == 12'h341) csr_rdata = mepc_m;
      end
   end

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard
   typedef struct {
      logic        xint;
      logic        xmpie;
      logic [30:0] xcause;
      logic [31:0] xpc;
      logic [31:0] xval;
   } trap_t;

   trap_t       trap_q[$];
   logic [31:0] wr_q[$];
   logic [31:0] rdir_q[$];
   trap_t       mon_t;
   logic [31:0] mon_w;

   always @(negedge clk) begin
      if (trap_wr_en === 1'b1) begin
         if (trap_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_trap: got trap_wr_en=1 expected no trap write");
         end else begin
            mon_t = trap_q.pop_front();
            chk("trap_cause", {1'b0, trap_cause}, {1'b0, mon_t.xcause});
            chk("trap_pc", trap_pc_out, mon_t.xpc);
            chk("trap_val", trap_val, mon_t.xval);
            chk("trap_int_mpie_mie", {29'd0, trap_int, trap_mpie, trap_mie},
                {29'd0, mon_t.xint, mon_t.xmpie, 1'b0});
            chk("trap_mtvec_read", {19'd0, csr_read_en, csr_addr}, {19'd0, 1'b1, 12'h305});
         end
      end
      if (csr_write_en === 1'b1) begin
         if (wr_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_csr_write: got addr %h expected no write", csr_addr);
         end else begin
            mon_w = wr_q.pop_front();
            chk("mret_wdata", csr_wdata, mon_w);
            chk("mret_waddr_type", {18'd0, csr_write_type, csr_addr}, {18'd0, 2'd0, 12'h300});
         end
      end
      if (csr_read_en === 1'b1 && trap_wr_en !== 1'b1)
         chk("mepc_read_addr", {20'd0, csr_addr}, 32'h341);
      if (redirect_valid === 1'b1) begin
         if (rdir_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
         end else begin
            mon_w = rdir_q.pop_front();
            chk("redirect_pc", redirect_pc, mon_w);
         end
      end
   end

   // Vector table
   typedef struct {
      logic        exc, mret, ok, mie, mpie;
      logic [2:0]  ip, ie;          // {MEI, MSI, MTI}
      logic [30:0] ecause;
      logic [31:0] epc, evalue, ipc, mtvec, mepc;
      int          kind;            // 0 trap, 1 mret, 2 nothing taken
      logic        xint, xmpie;
      logic [30:0] xcause;
      logic [31:0] xpc, xval, xwdata, xrpc;
   } vec_t;

   function automatic vec_t blank();
      vec_t v;
      v.exc = 0; v.mret = 0; v.ok = 0; v.mie = 0; v.mpie = 0;
      v.ip = 0; v.ie = 0; v.ecause = 0; v.epc = 0; v.evalue = 0;
      v.ipc = 0; v.mtvec = 0; v.mepc = 0; v.kind = 2; v.xint = 0;
      v.xmpie = 0; v.xcause = 0; v.xpc = 0; v.xval = 0; v.xwdata = 0; v.xrpc = 0;
      return v;
   endfunction

   function automatic vec_t mk_exc(logic mie, logic [30:0] c, logic [31:0] pc,
                                   logic [31:0] val, logic [31:0] mtvec,
                                   logic [31:0] rpc, logic all);
      vec_t v = blank();
      v.exc = 1; v.mie = mie; v.ecause = c; v.epc = pc; v.evalue = val; v.mtvec = mtvec;
      if (all) begin v.mret = 1; v.ok = 1; v.ip = 3'b111; v.ie = 3'b111; end
      v.kind = 0; v.xint = 0; v.xmpie = mie; v.xcause = c; v.xpc = pc; v.xval = val;
      v.xrpc = rpc;
      return v;
   endfunction

   function automatic vec_t mk_int(logic [2:0] ip, logic [2:0] ie, logic [31:0] ipc,
                                   logic [31:0] mtvec, logic [30:0] xc, logic [31:0] rpc);
      vec_t v = blank();
      v.ok = 1; v.mie = 1; v.ip = ip; v.ie = ie; v.ipc = ipc; v.mtvec = mtvec;
      v.epc = 32'hDEAD0000; v.evalue = 32'h5555AAAA;
      v.kind = 0; v.xint = 1; v.xmpie = 1; v.xcause = xc; v.xpc = ipc; v.xval = 0;
      v.xrpc = rpc;
      return v;
   endfunction

   function automatic vec_t mk_mret(logic [31:0] mepc, logic mpie,
                                    logic [31:0] wd, logic [31:0] rpc);
      vec_t v = blank();
      v.mret = 1; v.mepc = mepc; v.mpie = mpie; v.kind = 1; v.xwdata = wd; v.xrpc = rpc;
      return v;
   endfunction

   function automatic vec_t mk_none(logic mie, logic ok, logic [2:0] ip, logic [2:0] ie);
      vec_t v = blank();
      v.mie = mie; v.ok = ok; v.ip = ip; v.ie = ie; v.ipc = 32'h1234;
      return v;
   endfunction

   vec_t vecs[13];

   task automatic clear_requests();
      exc_valid = 0; mret_valid = 0; int_ok = 0;
      mip_meip_in = 0; mip_msip_in = 0; mip_mtip_in = 0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cycles, exp_cycles;
      trap_t t;
      @(negedge clk);
      exc_valid = v.exc; mret_valid = v.mret; int_ok = v.ok;
      exc_cause = v.ecause; exc_pc = v.epc; exc_val = v.evalue; int_pc = v.ipc;
      mstatus_mie_in = v.mie; mstatus_mpie_in = v.mpie;
      {mip_meip_in, mip_msip_in, mip_mtip_in} = v.ip;
      {mie_meie_in, mie_msie_in, mie_mtie_in} = v.ie;
      mtvec_m = v.mtvec; mepc_m = v.mepc;
      if (v.kind == 0) begin
         t.xint = v.xint; t.xmpie = v.xmpie; t.xcause = v.xcause;
         t.xpc = v.xpc; t.xval = v.xval;
         trap_q.push_back(t);
         rdir_q.push_back(v.xrpc);
      end else if (v.kind == 1) begin
         wr_q.push_back(v.xwdata);
         rdir_q.push_back(v.xrpc);
      end
      @(posedge clk);
      if (v.kind == 2) begin
         repeat (5) begin
            @(negedge clk);
            chk("masked_idle", {30'd0, busy, trap_wr_en}, 32'd0);
            @(posedge clk);
         end
      end
      @(negedge clk);
      clear_requests();
      cycles = 0;
      while (busy === 1'b1 && cycles < 10) begin
         cycles++;
         @(negedge clk);
      end
      exp_cycles = (v.kind == 0) ? 2 : ((v.kind == 1) ? 3 : 0);
      chk("busy_cycles", cycles, exp_cycles);
      $display("[TB] vec %0d kind %0d busy %0d cycles", idx, v.kind, cycles);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {16'd0, csr_addr, csr_read_en, csr_write_en, csr_write_type},  32'd0);
      chk({name, "_wdata"}, csr_wdata | trap_pc_out | trap_val | redirect_pc, 32'd0);
      chk({name, "_flags"}, {1'b0, trap_cause} |
          {26'd0, trap_mie, trap_mpie, trap_int, trap_wr_en, redirect_valid, busy}, 32'd0);
   endtask

   initial begin
      vecs[0]  = mk_exc(1'b1, 31'd2, 32'h8AB4, 32'hFFEEDD11, 32'h4, 32'h4, 1'b0);
      vecs[1]  = mk_int(3'b111, 3'b111, 32'h8A9C, 32'h101, 31'd11, 32'h12C);
      vecs[2]  = mk_int(3'b011, 3'b111, 32'h8A9C, 32'h101, 31'd3, 32'h10C);
      vecs[3]  = mk_int(3'b001, 3'b111, 32'h8A9C, 32'h101, 31'd7, 32'h11C);
      vecs[4]  = mk_none(1'b0, 1'b1, 3'b111, 3'b111);
      vecs[5]  = mk_none(1'b1, 1'b0, 3'b111, 3'b111);
      vecs[6]  = mk_none(1'b1, 1'b1, 3'b111, 3'b000);
      vecs[7]  = mk_exc(1'b1, 31'd5, 32'h1000, 32'hABCD, 32'h101, 32'h100, 1'b1);
      vecs[8]  = mk_mret(32'h8A9E, 1'b1, 32'h88, 32'h8A9C);
      vecs[9]  = mk_exc(1'b0, 31'd7, 32'h2000, 32'h0, 32'h103, 32'h100, 1'b0);
      vecs[10] = mk_int(3'b010, 3'b010, 32'h4444, 32'h202, 31'd3, 32'h200);
      vecs[11] = mk_mret(32'h1003, 1'b0, 32'h80, 32'h1000);
      vecs[12] = mk_int(3'b100, 3'b100, 32'h4448, 32'hFFFFFFFD, 31'd11, 32'h28);

      // Reset with random inputs
      reset = 0;
      mtvec_m = 0; mepc_m = 0;
      exc_cause = 0; exc_pc = 0; exc_val = 0; int_pc = 0;
      mstatus_mie_in = 0; mstatus_mpie_in = 0;
      mie_meie_in = 0; mie_msie_in = 0; mie_mtie_in = 0;
      clear_requests();
      repeat (2) begin
         {exc_valid, mret_valid, int_ok, mstatus_mie_in} = 4'($urandom);
         {mip_meip_in, mip_msip_in, mip_mtip_in} = 3'($urandom);
         {mie_meie_in, mie_msie_in, mie_mtie_in} = 3'($urandom);
         exc_cause = 31'($urandom); exc_pc = $urandom; int_pc = $urandom;
         @(posedge clk);
         @(negedge clk);
         chk_all_zero("reset_outputs");
      end
      clear_requests();
      reset = 1;
      repeat (3) begin
         @(negedge clk);
         chk_all_zero("idle_after_reset");
      end

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // Reset asserted while in TRAP_WR
      @(negedge clk);
      exc_valid = 1; exc_cause = 31'd4; exc_pc = 32'h3000; exc_val = 32'h77;
      mstatus_mie_in = 1; mtvec_m = 32'h40;
      begin
         trap_t t;
         t.xint = 0; t.xmpie = 1; t.xcause = 31'd4; t.xpc = 32'h3000; t.xval = 32'h77;
         trap_q.push_back(t);
      end
      @(posedge clk);
      @(negedge clk);          // in TRAP_WR: monitor consumes the trap record
      chk("midreset_in_trap_wr", {31'd0, trap_wr_en}, 32'd1);
      clear_requests();
      reset = 0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midreset_outputs");
      reset = 1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("midreset_no_redirect", {31'd0, redirect_valid | busy}, 32'd0);
      end
      run_vec(100, vecs[0]);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", trap_q.size() + wr_q.size() + rdir_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap sequencer that sits between the pipeline and `csr_reg` and drives that block's trap-write and CSR-access ports. It does three things:
- Arbitrates synchronous exceptions, machine-level interrupts and `mret` requests.
- Sequences the required CSR reads and writes: `mtvec`, `mepc` and `mstatus`.
- Issues a single-cycle PC redirect to fetch.

## Interface
- `MTVEC_ADDR`, default 12'h305: CSR address read for the trap vector.
- `MEPC_ADDR`, default 12'h341: CSR address read on `mret`.
- `MSTATUS_ADDR`, default 12'h300: CSR address written on `mret`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low.
- `exc_valid` in 1: exception request from the execute stage.
- `exc_cause` in 31: exception code.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_val` in 32: value for `mtval`.
- `mret_valid` in 1: `mret` request from the execute stage.
- `int_ok` in 1: pipeline is at an interruptible boundary.
- `int_pc` in 32: PC of the next instruction to execute; used as `mepc` for interrupts.
- `mstatus_mie_in`, `mip_msip_in`, `mip_mtip_in`, `mip_meip_in`, `mie_msie_in`, `mie_mtie_in`, `mie_meie_in` in 1 each: status and enable bits from `csr_reg`.
- `csr_rdata` in 32: `csr_reg` `dout`, which is combinational from `addr`/`read_en`.
- `csr_addr` out 12, `csr_read_en` out 1, `csr_write_en` out 1, `csr_write_type` out 2, `csr_wdata` out 32: CSR port. Write types: 0 = write, 1 = set, 2 = clear.
- `trap_mie`, `trap_mpie`, `trap_int` out 1 each; `trap_pc_out` out 32; `trap_cause` out 31; `trap_val` out 32; `trap_wr_en` out 1: trap-write port of `csr_reg`.
- `redirect_valid` out 1: single-cycle pulse to fetch.
- `redirect_pc` out 32: target PC, valid with `redirect_valid`.
- `busy` out 1: high in every state except IDLE; the pipeline stalls while it is high.

## Operation
- States: IDLE, TRAP_WR, MRET_RD, MRET_WR, REDIRECT.
- In IDLE, requests are sampled at the rising edge with this priority:
  1. `exc_valid`
  2. Interrupt. Taken only if `int_ok` and `mstatus_mie_in` are both 1 and at least one `mip & mie` pair is set. Source order is MEI (cause 11), then MSI (3), then MTI (7).
  3. `mret_valid`
- Lower-priority requests in the same cycle are dropped. Requests arriving while `busy` is high are ignored.
- Accepting a trap latches four values and moves to TRAP_WR:
  - `int`: 0 for an exception, 1 for an interrupt.
  - `cause`.
  - `pc`: `exc_pc` for an exception, `int_pc` for an interrupt.
  - `val`: `exc_val` for an exception, 0 for an interrupt.
  - `mpie` is taken as `mstatus_mie_in` sampled in the same cycle.
- TRAP_WR drives the following for one cycle:
  - `trap_wr_en`=1, `trap_mie`=0, `trap_mpie`=latched value, and the latched pc, cause, int and val on the trap port.
  - Simultaneously `csr_addr`=`MTVEC_ADDR` and `csr_read_en`=1; `csr_rdata` is latched as the vector.
  - Next state is REDIRECT.
- Redirect target from the latched vector:
  - base = {mtvec[31:2], 2'b00}.
  - mode = mtvec[1:0]. Mode 1 with `int`=1 gives base + (cause << 2), with the 32-bit result wrapping.
  - All other cases give base. Modes 2 and 3 are treated as direct.
- Accepting `mret` moves to MRET_RD:
  - MRET_RD: `csr_addr`=`MEPC_ADDR`, `csr_read_en`=1; latch `csr_rdata` & ~32'h3.
  - MRET_WR: `csr_addr`=`MSTATUS_ADDR`, `csr_write_en`=1, `csr_write_type`=0, `csr_wdata`=32'h80 | (`mstatus_mpie_in` << 3).
  - Next state is REDIRECT with `redirect_pc` = latched `mepc`.
- REDIRECT: `redirect_valid`=1 for one cycle, then IDLE.
- Outputs are combinational from state and latches. CSR-port and trap-port outputs are 0 in every state where they are not listed above.

## Timing
- Reset (`reset`=0 at the edge): the FSM goes to IDLE and all latches clear. Every output is 0, including `busy`, `redirect_valid`, `trap_wr_en`, `csr_*` and `redirect_pc`.
- Reset asserted in any state aborts the sequence at that edge; no further trap or CSR writes are issued.
- Trap latency: request accepted at edge N, TRAP_WR during cycle N..N+1, `redirect_valid` during cycle N+1..N+2, and IDLE (`busy`=0) after edge N+2.
- `mret` latency: one cycle longer than a trap, giving MRET_RD, MRET_WR, REDIRECT.
- A request held high through the REDIRECT cycle is re-accepted at the edge that returns to IDLE. The pipeline deasserts each request on `redirect_valid`.
- `csr_reg` updates mip/mstatus at the TRAP_WR edge. Interrupts are therefore re-evaluated only in IDLE, after those updates are visible.

## Test plan
- Reset: hold `reset`=0 for 2 edges with random inputs → all outputs 0 and `busy`=0; after release, outputs stay 0 with no requests.
- Exception: `mtvec`=0x4, `mstatus_mie_in`=1, exc cause 2, pc 0x8AB4, val 0xFFEEDD11 → next cycle `trap_wr_en`=1, `trap_mie`=0, `trap_mpie`=1, `trap_int`=0, cause 2, `trap_pc_out`=0x8AB4; following cycle `redirect_valid`=1, `redirect_pc`=0x4.
- Interrupt priority and vectoring:
  - Stimulus: all mip/mie bits 1, `mstatus_mie_in`=1, `int_ok`=1, `int_pc`=0x8A9C, `mtvec`=0x101.
  - Response: cause 11, `trap_int`=1, val 0, pc 0x8A9C; `redirect_pc`=0x12C.
  - Repeat with MEI cleared → cause 3; then with only MTI set → cause 7.
- Masking and arbitration:
  - `mstatus_mie_in`=0 or `int_ok`=0 with interrupts pending → no `trap_wr_en` over 5 cycles.
  - `exc_valid`, interrupt and `mret_valid` asserted together → cause = `exc_cause`, `trap_int`=0.
- MRET: `csr_rdata` returns 0x8A9E for `mepc`, `mstatus_mpie_in`=1 → cycle 1 read at 0x341; cycle 2 write at 0x300, type 0, data 0x88; cycle 3 `redirect_pc`=0x8A9C.
- Reset mid-sequence: drive `reset`=0 during TRAP_WR → next cycle all outputs 0 and no `redirect_valid`; after release, a new exception is accepted normally.
